// File: rtl/syscall_unit.sv
// Syscall service responder: latches $v0/$a0, stalls the CPU while it prints
// integers/strings/chars to a byte stream, services sbrk or halts.
module syscall_unit #(
    parameter logic [31:0] HEAP_BASE  = 32'h00000080,
    parameter logic [31:0] HEAP_LIMIT = 32'h00001000,
    parameter int          MAX_STR    = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        syscall,
    input  logic [31:0] v0_data,
    input  logic [31:0] a0_data,
    output logic        stall,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        mem_rd,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_rdata,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [31:0] heap_ptr,
    output logic        halted,
    output logic        err
);
    localparam int CNT_W = $clog2(MAX_STR + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_SIGN, S_CONV, S_IEMIT, S_SFETCH, S_SEMIT, S_CEMIT, S_DONE, S_HALT
    } state_t;

    state_t             state;
    logic [31:0]        code;
    logic [31:0]        arg;
    logic [31:0]        bin;
    logic [39:0]        bcd;
    logic [4:0]         bit_cnt;
    logic [3:0]         digit_idx;
    logic [CNT_W-1:0]   char_cnt;

    logic        tx_fire;
    logic [39:0] bcd_adj;
    logic [39:0] bcd_shift;
    logic [39:0] bcd_aligned;
    logic [3:0]  lead_idx;
    logic [7:0]  mem_byte;
    logic [31:0] sbrk_req;
    logic [32:0] heap_sum;
    logic        heap_fits;

    assign tx_fire  = tx_valid & tx_ready;
    assign rf_waddr = 5'd2;
    assign mem_rd   = (state == S_SFETCH);
    assign mem_addr = {arg[31:2], 2'b00};

    // One double-dabble step, plus the result left-aligned so the most
    // significant non-zero digit sits in bcd[39:36] ready for emission.
    always_comb begin
        bcd_adj  = '0;
        lead_idx = '0;
        for (int i = 0; i < 10; i++) begin
            bcd_adj[4*i +: 4] = (bcd[4*i +: 4] >= 4'd5) ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
        end
        bcd_shift = {bcd_adj[38:0], bin[31]};
        for (int i = 0; i < 10; i++) begin
            if (bcd_shift[4*i +: 4] != 4'd0) lead_idx = 4'(i);
        end
        bcd_aligned = bcd_shift << {4'd9 - lead_idx, 2'b00};
    end

    always_comb begin
        case (arg[1:0])
            2'd0:    mem_byte = mem_rdata[31:24];
            2'd1:    mem_byte = mem_rdata[23:16];
            2'd2:    mem_byte = mem_rdata[15:8];
            default: mem_byte = mem_rdata[7:0];
        endcase
    end

    // The 33-bit sum catches wrap-around as well as the heap limit.
    always_comb begin
        sbrk_req  = (arg + 32'd3) & ~32'd3;
        heap_sum  = {1'b0, heap_ptr} + {1'b0, sbrk_req};
        heap_fits = ~heap_sum[32] && (heap_sum[31:0] <= HEAP_LIMIT);
    end

    always_comb begin
        case (state)
            S_IDLE:  stall = syscall;
            S_DONE:  stall = 1'b0;
            default: stall = 1'b1;
        endcase
        rf_we    = (state == S_DONE) && (code == 32'd9);
        rf_wdata = rf_we ? (heap_fits ? heap_ptr : 32'hFFFF_FFFF) : 32'd0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            code      <= '0;
            arg       <= '0;
            bin       <= '0;
            bcd       <= '0;
            bit_cnt   <= '0;
            digit_idx <= '0;
            char_cnt  <= '0;
            tx_data   <= '0;
            tx_valid  <= 1'b0;
            heap_ptr  <= HEAP_BASE;
            halted    <= 1'b0;
            err       <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (syscall) begin
                    code <= v0_data;
                    arg  <= a0_data;
                    case (v0_data)
                        32'd1: begin
                            bin     <= a0_data[31] ? -a0_data : a0_data;
                            bcd     <= '0;
                            bit_cnt <= '0;
                            if (a0_data[31]) begin
                                tx_data  <= 8'h2D;
                                tx_valid <= 1'b1;
                                state    <= S_SIGN;
                            end else begin
                                state <= S_CONV;
                            end
                        end
                        32'd4: begin
                            char_cnt <= '0;
                            state    <= S_SFETCH;
                        end
                        32'd10: begin
                            halted <= 1'b1;
                            state  <= S_HALT;
                        end
                        32'd11: begin
                            tx_data  <= a0_data[7:0];
                            tx_valid <= 1'b1;
                            state    <= S_CEMIT;
                        end
                        default: state <= S_DONE;
                    endcase
                end
                S_SIGN: if (tx_fire) begin
                    tx_valid <= 1'b0;
                    state    <= S_CONV;
                end
                S_CONV: begin
                    bcd     <= bcd_shift;
                    bin     <= bin << 1;
                    bit_cnt <= bit_cnt + 5'd1;
                    if (bit_cnt == 5'd31) begin
                        bcd       <= bcd_aligned;
                        digit_idx <= lead_idx;
                        tx_data   <= {4'h3, bcd_aligned[39:36]};
                        tx_valid  <= 1'b1;
                        state     <= S_IEMIT;
                    end
                end
                // digit_idx counts the digits still to send after the current one.
                S_IEMIT: if (tx_fire) begin
                    if (digit_idx == 4'd0) begin
                        tx_valid <= 1'b0;
                        state    <= S_DONE;
                    end else begin
                        bcd       <= bcd << 4;
                        tx_data   <= {4'h3, bcd[35:32]};
                        digit_idx <= digit_idx - 4'd1;
                    end
                end
                S_SFETCH: begin
                    if (mem_byte == 8'd0 || char_cnt == CNT_W'(MAX_STR)) begin
                        state <= S_DONE;
                    end else begin
                        tx_data  <= mem_byte;
                        tx_valid <= 1'b1;
                        state    <= S_SEMIT;
                    end
                end
                S_SEMIT: if (tx_fire) begin
                    tx_valid <= 1'b0;
                    arg      <= arg + 32'd1;
                    char_cnt <= char_cnt + 1'b1;
                    state    <= S_SFETCH;
                end
                S_CEMIT: if (tx_fire) begin
                    tx_valid <= 1'b0;
                    state    <= S_DONE;
                end
                S_DONE: begin
                    if (code == 32'd9) begin
                        if (heap_fits) heap_ptr <= heap_sum[31:0];
                        else           err      <= 1'b1;
                    end
                    state <= S_IDLE;
                end
                S_HALT:  state <= S_HALT;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_syscall_unit.sv
// Directed bench for syscall_unit: a byte-stream scoreboard fed by a service
// model, per-cycle handshake checks and literal expectations.
module tb_syscall_unit;
    localparam logic [31:0] HEAP_BASE  = 32'h00000080;
    localparam logic [31:0] HEAP_LIMIT = 32'h00001000;
    localparam int          MAX_STR    = 256;

    logic        clk, reset, syscall;
    logic [31:0] v0_data, a0_data;
    logic        stall, rf_we, mem_rd, tx_valid, tx_ready, halted, err;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata, mem_addr, mem_rdata, heap_ptr;
    logic [7:0]  tx_data;

    syscall_unit #(.HEAP_BASE(HEAP_BASE), .HEAP_LIMIT(HEAP_LIMIT), .MAX_STR(MAX_STR)) dut (
        .clk(clk), .reset(reset), .syscall(syscall), .v0_data(v0_data), .a0_data(a0_data),
        .stall(stall), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .heap_ptr(heap_ptr), .halted(halted), .err(err)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] mem [0:1023];
    assign mem_rdata = mem[mem_addr[11:2]];

    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;
    bit ready_mode = 0;

    always @(posedge clk) begin
        #1;
        cyc++;
        tx_ready = ready_mode ? (cyc % 3 == 0) : 1'b1;
    end

    // ---------------- scoreboard ----------------
    logic [7:0]  exp_q[$];
    logic [7:0]  got_q[$];
    logic [31:0] m_heap;
    logic        m_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic [31:0] got_at(input int i);
        return (i < got_q.size()) ? {24'd0, got_q[i]} : 32'hDEAD_BEEF;
    endfunction

    bit          hold_v = 0;
    logic [7:0]  hold_d;

    always @(negedge clk) begin
        if (reset) begin
            hold_v = 0;
        end else begin
            if (hold_v) chk("tx_stable", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, hold_d});
            if (tx_valid && tx_ready) begin
                got_q.push_back(tx_data);
                if (exp_q.size() == 0) begin
                    n_total++;
                    $display("FAIL tx_unexpected: got byte %h expected none (t=%0t)", tx_data, $time);
                end else begin
                    chk("tx_byte", {24'd0, tx_data}, {24'd0, exp_q.pop_front()});
                end
            end
            hold_v = tx_valid && !tx_ready;
            hold_d = tx_data;
            if (rf_we)  chk("rf_waddr", {27'd0, rf_waddr}, 32'd2);
            if (mem_rd) chk("mem_addr_align", {30'd0, mem_addr[1:0]}, 32'd0);
        end
    end

    // ---------------- service model ----------------
    task automatic expect_int(input logic [31:0] a);
        string s;
        s = $sformatf("%0d", $signed(a));
        for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
    endtask

    task automatic expect_str(input logic [31:0] a);
        logic [31:0] ad, w;
        logic [7:0]  b;
        for (int i = 0; i < MAX_STR; i++) begin
            ad = a + i;
            w  = mem[ad[11:2]];
            b  = 8'(w >> (8 * (3 - ad[1:0])));
            if (b == 8'd0) break;
            exp_q.push_back(b);
        end
    endtask

    task automatic sbrk_model(input logic [31:0] a, output logic [31:0] res);
        logic [31:0] req;
        logic [63:0] top;
        req = (a + 32'd3) & ~32'd3;
        top = 64'(m_heap) + 64'(req);
        if (top <= 64'(HEAP_LIMIT) && top < 64'h1_0000_0000) begin
            res    = m_heap;
            m_heap = top[31:0];
        end else begin
            res   = 32'hFFFF_FFFF;
            m_err = 1'b1;
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic run_call(input logic [31:0] v, input logic [31:0] a, input int budget,
                            output int cycles, output bit we_seen, output logic [31:0] wdata);
        @(posedge clk); #1;
        syscall = 1'b1; v0_data = v; a0_data = a;
        cycles = 0; we_seen = 0; wdata = '0;
        forever begin
            @(negedge clk);
            cycles++;
            if (rf_we) begin we_seen = 1; wdata = rf_wdata; end
            if (!stall) break;
            if (cycles >= budget) begin
                n_total++;
                $display("FAIL call_timeout: code %0d still stalled after %0d cycles", v, cycles);
                break;
            end
        end
        @(posedge clk); #1;
        syscall = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1; syscall = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        m_heap = HEAP_BASE; m_err = 1'b0;
        exp_q.delete(); got_q.delete();
    endtask

    task automatic int_call(input logic [31:0] a);
        int c; bit we; logic [31:0] wd;
        got_q.delete();
        expect_int(a);
        run_call(32'd1, a, 200, c, we, wd);
        chk("int_no_rf_we", {31'd0, we}, 32'd0);
        chk("int_drained", exp_q.size(), 32'd0);
    endtask

    task automatic sbrk_call(input logic [31:0] a, input logic [31:0] lit_res, input logic [31:0] lit_heap);
        int c; bit we; logic [31:0] wd, mres;
        sbrk_model(a, mres);
        run_call(32'd9, a, 10, c, we, wd);
        chk("sbrk_we", {31'd0, we}, 32'd1);
        chk("sbrk_result_model", wd, mres);
        chk("sbrk_result_lit", wd, lit_res);
        chk("sbrk_heap_model", heap_ptr, m_heap);
        chk("sbrk_heap_lit", heap_ptr, lit_heap);
        chk("sbrk_err", {31'd0, err}, {31'd0, m_err});
    endtask

    // ---------------- directed tests ----------------
    initial begin
        int c; bit we; logic [31:0] wd;
        reset = 1'b1; syscall = 1'b0; v0_data = '0; a0_data = '0;
        for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
        mem[32'h100 >> 2] = 32'h48690000;
        for (int i = 32'h200 >> 2; i < 1024; i++) mem[i] = 32'h41424344;
        m_heap = HEAP_BASE; m_err = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
        chk("rst_tx_data", {24'd0, tx_data}, 32'd0);
        chk("rst_rf_we", {31'd0, rf_we}, 32'd0);
        chk("rst_mem_rd", {31'd0, mem_rd}, 32'd0);
        chk("rst_heap", heap_ptr, 32'h80);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);

        // print_int, negative
        int_call(32'hFFFF_FECF);
        chk("neg_len", got_q.size(), 32'd4);
        chk("neg_b0", got_at(0), 32'h2D);
        chk("neg_b1", got_at(1), 32'h33);
        chk("neg_b2", got_at(2), 32'h30);
        chk("neg_b3", got_at(3), 32'h35);

        int_call(32'd0);
        chk("zero_len", got_q.size(), 32'd1);
        chk("zero_b0", got_at(0), 32'h30);
        int_call(32'h8000_0000);
        chk("min_len", got_q.size(), 32'd11);
        chk("min_b1", got_at(1), 32'h32);
        chk("min_b10", got_at(10), 32'h38);
        int_call(32'h7FFF_FFFF);
        int_call(32'd1000000007);

        // print_string under back-pressure, then unaligned start
        ready_mode = 1;
        got_q.delete();
        expect_str(32'h100);
        run_call(32'd4, 32'h100, 100, c, we, wd);
        chk("str_len", got_q.size(), 32'd2);
        chk("str_b0", got_at(0), 32'h48);
        chk("str_b1", got_at(1), 32'h69);
        chk("str_drained", exp_q.size(), 32'd0);
        got_q.delete();
        expect_str(32'h101);
        run_call(32'd4, 32'h101, 100, c, we, wd);
        chk("str_unal_b0", got_at(0), 32'h69);
        ready_mode = 0;

        // string with no terminator stops at MAX_STR
        got_q.delete();
        expect_str(32'h200);
        run_call(32'd4, 32'h200, 2000, c, we, wd);
        chk("maxstr_len", got_q.size(), MAX_STR);
        chk("maxstr_drained", exp_q.size(), 32'd0);

        // print_char
        got_q.delete();
        exp_q.push_back(8'h5A);
        run_call(32'd11, 32'h1234_565A, 20, c, we, wd);
        chk("char_b0", got_at(0), 32'h5A);
        chk("char_no_rf_we", {31'd0, we}, 32'd0);

        // sbrk
        do_reset();
        sbrk_call(32'd5, 32'h80, 32'h88);
        sbrk_call(32'd8, 32'h88, 32'h90);
        sbrk_call(32'h0001_0000, 32'hFFFF_FFFF, 32'h90);
        chk("sbrk_err_lit", {31'd0, err}, 32'd1);
        sbrk_call(32'd0, 32'h90, 32'h90);
        sbrk_call(32'hF70, 32'h90, 32'h1000);
        sbrk_call(32'd1, 32'hFFFF_FFFF, 32'h1000);
        sbrk_call(32'hFFFF_F000, 32'hFFFF_FFFF, 32'h1000);

        // exit, then a print_char that must be ignored
        @(posedge clk); #1;
        syscall = 1'b1; v0_data = 32'd10; a0_data = 32'd0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("halt_stall", {31'd0, stall}, 32'd1);
            if (i > 0) chk("halt_flag", {31'd0, halted}, 32'd1);
        end
        @(posedge clk); #1;
        syscall = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("halt_stall_idle", {31'd0, stall}, 32'd1);
        end
        @(posedge clk); #1;
        syscall = 1'b1; v0_data = 32'd11; a0_data = 32'h41;
        repeat (5) begin
            @(negedge clk);
            chk("halt_no_tx", {31'd0, tx_valid}, 32'd0);
            chk("halt_stall_call", {31'd0, stall}, 32'd1);
        end
        do_reset();
        @(negedge clk);
        chk("halt_cleared", {31'd0, halted}, 32'd0);
        chk("halt_clr_stall", {31'd0, stall}, 32'd0);

        // reset in the middle of print_string
        sbrk_call(32'd4, 32'h80, 32'h84);
        expect_str(32'h200);
        @(posedge clk); #1;
        syscall = 1'b1; v0_data = 32'd4; a0_data = 32'h200;
        repeat (7) @(posedge clk);
        #1 reset = 1'b1; syscall = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0;
        exp_q.delete();
        m_heap = HEAP_BASE; m_err = 1'b0;
        @(negedge clk);
        chk("mid_rst_tx_valid", {31'd0, tx_valid}, 32'd0);
        chk("mid_rst_stall", {31'd0, stall}, 32'd0);
        chk("mid_rst_heap", heap_ptr, 32'h80);

        // unknown code costs exactly one stalled cycle then DONE
        got_q.delete();
        run_call(32'd42, 32'd0, 10, c, we, wd);
        chk("unk_cycles", c, 32'd2);
        chk("unk_rf_we", {31'd0, we}, 32'd0);
        chk("unk_no_tx", got_q.size(), 32'd0);
        chk("unk_heap", heap_ptr, m_heap);

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/syscall_unit.md
Name: syscall_unit

Overview:
Service-side responder for the CPU's syscall interface. When the datapath decodes `syscall`, this block latches the service code ($v0) and the argument ($a0), then stalls the CPU while it performs the service. Services are console output over a byte stream, heap allocation (sbrk) and exit. When the service finishes, it returns a result to $v0 through a register-file write port and releases the stall.

Parameters:
HEAP_BASE, 32'h00000080, initial heap pointer (byte address, word aligned)
HEAP_LIMIT, 32'h00001000, exclusive upper bound of the heap
MAX_STR, 256, maximum characters emitted per print_string

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
syscall  in  1  CPU is executing a syscall; held high while stall=1
v0_data  in  32  current $v0 (service code)
a0_data  in  32  current $a0 (argument)
stall  out  1  freeze PC and CPU register writes
rf_we  out  1  register-file write enable for the service result
rf_waddr  out  5  result register, always 5'd2
rf_wdata  out  32  result value
mem_rd  out  1  data-memory read strobe
mem_addr  out  32  word-aligned read address
mem_rdata  in  32  combinational read data, valid in the same cycle
tx_data  out  8  console byte
tx_valid  out  1  tx_data valid
tx_ready  in  1  sink accepts byte
heap_ptr  out  32  current heap pointer
halted  out  1  exit service taken
err  out  1  sticky sbrk overflow flag

Behaviour:
- Reset (synchronous, also mid-operation): state=IDLE, tx_valid=0, tx_data=0, rf_we=0, mem_rd=0, heap_ptr=HEAP_BASE, halted=0, err=0, counters cleared.
- stall (combinational):
  - IDLE: stall = syscall.
  - DONE: stall = 0.
  - All other states (including HALT): stall = 1.
  - Minimum syscall cost: 2 cycles (IDLE, DONE).
- IDLE with syscall=1: latch code=v0_data and arg=a0_data, then dispatch:
  - 1 print_int → CONV
  - 4 print_string → SFETCH
  - 9 sbrk → DONE (result computed in DONE)
  - 10 exit → HALT
  - 11 print_char → CEMIT with tx_data=arg[7:0]
  - any other code → DONE, with no side effects
- print_int:
  - Negative arg: first emit 0x2D ('-'), then convert the magnitude, computed as unsigned 32-bit (0x80000000 gives 2147483648).
  - CONV: double-dabble into 10 BCD digits, exactly 32 cycles.
  - IEMIT: emit digits MS→LS, suppressing leading zeros; value 0 emits a single 0x30.
  - After the last digit is accepted → DONE.
- print_string:
  - SFETCH: mem_rd=1, mem_addr={ptr[31:2],2'b00}. Byte select is big-endian: ptr[1:0]=0 → bits [31:24].
  - Byte==0 or count==MAX_STR → DONE; otherwise → SEMIT.
  - SEMIT: on acceptance, ptr++, count++, → SFETCH. NUL is never transmitted.
- Tx handshake:
  - Transfer occurs on a rising edge with tx_valid & tx_ready.
  - tx_valid and tx_data stay stable until transfer.
  - tx_valid drops the cycle after the last byte of a service unless another byte follows immediately.
  - tx_ready is ignored while tx_valid=0.
- sbrk, in DONE:
  - req = (arg+3) & ~3.
  - If heap_ptr+req ≤ HEAP_LIMIT with no 32-bit carry: rf_wdata=old heap_ptr, and heap_ptr+=req on the DONE edge.
  - Otherwise: rf_wdata=32'hFFFFFFFF, heap_ptr unchanged, err←1 (sticky until reset).
  - rf_we=1 and rf_waddr=2 for that single DONE cycle.
  - arg=0 returns heap_ptr unchanged.
- DONE: lasts one cycle. rf_we=1 only for sbrk. The syscall input is ignored in DONE; next state is IDLE. Back-to-back syscalls are re-detected in IDLE on the following cycle.
- HALT: halted=1 and stall=1 permanently, all inputs ignored; left only by reset.
- rf_we=0 and mem_rd=0 in every state except those listed above.
- The CPU controller masks its own RegWrite while stall=1 or syscall=1.

Test Plan:
1. v0=1, a0=-305 (32'hFFFFFECF), tx_ready=1 → bytes 0x2D,0x33,0x30,0x35; stall=1 until the DONE cycle, where stall=0 for one cycle; rf_we never asserted.
2. print_int a0=0 → single 0x30. a0=32'h80000000 → "-2147483648" (11 bytes).
3. Memory word at 0x100 = 32'h48690000; v0=4, a0=0x100; tx_ready toggling 1-of-3 cycles → 0x48 then 0x69, each held stable while ready=0; no 0x00 sent.
4. Reset, then sbrk a0=5 → v0 write 0x80, heap_ptr=0x88. Then sbrk a0=8 → v0 write 0x88, heap_ptr=0x90. Then sbrk a0=32'h00010000 → v0 write 32'hFFFFFFFF, err=1, heap_ptr=0x90.
5. v0=10 → halted=1, stall=1 on all following cycles; a later syscall with v0=11 produces no tx_valid; reset clears halted.
6. Reset asserted mid print_string → next cycle tx_valid=0, stall=0, heap_ptr=HEAP_BASE. Then v0=42 → exactly one stalled cycle followed by DONE, with no outputs.
